// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle add/sub/mul/div floating-point unit.
// Accepts one operation at a time through a valid/ready handshake, computes
// it over UNPACK/EXEC/NORM, and holds the result until the consumer takes it.
// All rounding is toward zero; subnormal inputs are read as signed zero.
module fpu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] rs1,
   input  logic [EXP_W+MAN_W:0] rs2,
   input  logic [2:0]           funct3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [3:0]           flags
);

   localparam int FW   = 1 + EXP_W + MAN_W;
   localparam int MW   = MAN_W + 1;
   localparam int AW   = MAN_W + 4;
   localparam int NW   = 2 * MAN_W + 2;
   localparam int LW   = $clog2(NW) + 1;
   localparam int XW   = EXP_W + LW + 2;
   localparam int SHW  = $clog2(2 * AW) + 1;
   localparam int CW   = $clog2(MAN_W + 2);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
   localparam logic [MAN_W-1:0]      FRAC_ZERO = '0;
   localparam logic [FW-1:0]         CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [XW-1:0]  BIAS_X    = XW'(BIAS);
   localparam logic signed [XW-1:0]  EXP_MAX_X = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0]  REF_X     = XW'(NW - 2);
   localparam logic signed [XW-1:0]  ONE_X     = XW'(1);
   localparam logic [CW-1:0]         DIV_LAST  = CW'(MAN_W + 1);
   localparam logic [SHW-1:0]        SH_CLAMP  = SHW'(AW + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      EXEC   = 3'd2,
      NORM   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                r_state;
   logic [FW-1:0]         r_a;
   logic [FW-1:0]         r_b;
   logic [2:0]            r_op;
   logic [FW-1:0]         r_result;
   logic [3:0]            r_flags;
   logic                  r_outValid;
   logic                  r_sign;
   logic signed [XW-1:0]  r_exp;
   logic [NW-1:0]         r_norm;
   logic [MW:0]           r_rem;
   logic [MAN_W+1:0]      r_quot;
   logic [CW-1:0]         r_cnt;

   // Operand fields and classification, read from the captured operands
   logic                  w_sA, w_sB, w_sBe, w_isAddSub;
   logic [EXP_W-1:0]      w_eA, w_eB;
   logic [MAN_W-1:0]      w_fA, w_fB;
   logic [MW-1:0]         w_mA, w_mB;
   logic                  w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_snanA, w_snanB;
   logic signed [XW-1:0]  w_eAx, w_eBx;

   assign w_sA       = r_a[FW-1];
   assign w_sB       = r_b[FW-1];
   assign w_eA       = r_a[FW-2 -: EXP_W];
   assign w_eB       = r_b[FW-2 -: EXP_W];
   assign w_fA       = r_a[MAN_W-1:0];
   assign w_fB       = r_b[MAN_W-1:0];
   assign w_mA       = {1'b1, w_fA};
   assign w_mB       = {1'b1, w_fB};
   assign w_sBe      = w_sB ^ (r_op == OP_SUB);
   assign w_isAddSub = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_zeroA    = (w_eA == '0);
   assign w_zeroB    = (w_eB == '0);
   assign w_infA     = (w_eA == EXP_ONES) && (w_fA == '0);
   assign w_infB     = (w_eB == EXP_ONES) && (w_fB == '0);
   assign w_nanA     = (w_eA == EXP_ONES) && (w_fA != '0);
   assign w_nanB     = (w_eB == EXP_ONES) && (w_fB != '0);
   assign w_snanA    = w_nanA && !w_fA[MAN_W-1];
   assign w_snanB    = w_nanB && !w_fB[MAN_W-1];
   assign w_eAx      = {{(XW-EXP_W){1'b0}}, w_eA};
   assign w_eBx      = {{(XW-EXP_W){1'b0}}, w_eB};

   logic                  w_special;
   logic [FW-1:0]         w_specRes;
   logic [3:0]            w_specFlags;

   // Decide whether the operation bypasses the datapath, and its fixed result
   always_comb begin
      w_special   = 1'b1;
      w_specRes   = CANON_NAN;
      w_specFlags = 4'b0000;
      if (r_op[2]) begin
         w_specFlags = 4'b1000;
      end else if (w_nanA || w_nanB) begin
         w_specFlags = {(w_snanA || w_snanB), 3'b000};
      end else if (w_isAddSub) begin
         if (w_infA && w_infB) begin
            if (w_sA != w_sBe) w_specFlags = 4'b1000;
            else               w_specRes   = {w_sA, EXP_ONES, FRAC_ZERO};
         end else if (w_infA) begin
            w_specRes = {w_sA, EXP_ONES, FRAC_ZERO};
         end else if (w_infB) begin
            w_specRes = {w_sBe, EXP_ONES, FRAC_ZERO};
         end else if (w_zeroA && w_zeroB) begin
            w_specRes = {(w_sA & w_sBe), {(FW-1){1'b0}}};
         end else if (w_zeroA) begin
            w_specRes = {w_sBe, r_b[FW-2:0]};
         end else if (w_zeroB) begin
            w_specRes = r_a;
         end else begin
            w_special = 1'b0;
         end
      end else if (r_op == OP_MUL) begin
         if ((w_zeroA && w_infB) || (w_infA && w_zeroB)) begin
            w_specFlags = 4'b1000;
         end else if (w_infA || w_infB) begin
            w_specRes = {(w_sA ^ w_sB), EXP_ONES, FRAC_ZERO};
         end else if (w_zeroA || w_zeroB) begin
            w_specRes = {(w_sA ^ w_sB), {(FW-1){1'b0}}};
         end else begin
            w_special = 1'b0;
         end
      end else begin
         if ((w_zeroA && w_zeroB) || (w_infA && w_infB)) begin
            w_specFlags = 4'b1000;
         end else if (w_infA) begin
            w_specRes = {(w_sA ^ w_sB), EXP_ONES, FRAC_ZERO};
         end else if (w_zeroB) begin
            w_specRes   = {(w_sA ^ w_sB), EXP_ONES, FRAC_ZERO};
            w_specFlags = 4'b0100;
         end else if (w_infB || w_zeroA) begin
            w_specRes = {(w_sA ^ w_sB), {(FW-1){1'b0}}};
         end else begin
            w_special = 1'b0;
         end
      end
   end

   logic                  w_aGeB, w_sBig;
   logic [EXP_W-1:0]      w_eBig, w_eSml, w_expDiff;
   logic [MW-1:0]         w_mBig, w_mSml;
   logic [SHW-1:0]        w_shAmt;
   logic [2*AW-1:0]       w_alignWide;
   logic [AW-1:0]         w_alignSml, w_bigExt;
   logic [AW:0]           w_sum;

   // Add/sub: order by magnitude, align the smaller with guard/round/sticky, then add or subtract
   always_comb begin
      w_aGeB    = (r_a[FW-2:0] >= r_b[FW-2:0]);
      w_eBig    = w_aGeB ? w_eA : w_eB;
      w_eSml    = w_aGeB ? w_eB : w_eA;
      w_mBig    = w_aGeB ? w_mA : w_mB;
      w_mSml    = w_aGeB ? w_mB : w_mA;
      w_sBig    = w_aGeB ? w_sA : w_sBe;
      w_expDiff = w_eBig - w_eSml;
      if (32'(w_expDiff) > AW) w_shAmt = SH_CLAMP;
      else                     w_shAmt = SHW'(w_expDiff);
      w_alignWide = {w_mSml, 3'b000, {AW{1'b0}}} >> w_shAmt;
      w_alignSml  = w_alignWide[2*AW-1:AW] | {{(AW-1){1'b0}}, (|w_alignWide[AW-1:0])};
      w_bigExt    = {w_mBig, 3'b000};
      if (w_sA == w_sBe) w_sum = {1'b0, w_bigExt} + {1'b0, w_alignSml};
      else               w_sum = {1'b0, w_bigExt} - {1'b0, w_alignSml};
   end

   logic [NW-1:0]         w_prod;
   logic [MW+1:0]         w_remSub;
   logic                  w_qBit;
   logic [MW:0]           w_remKeep, w_remNext;
   logic [MAN_W+1:0]      w_quotNext;

   // Multiplier product and one restoring-division step
   always_comb begin
      w_prod     = NW'(w_mA) * NW'(w_mB);
      w_remSub   = {1'b0, r_rem} - {2'b00, w_mB};
      w_qBit     = ~w_remSub[MW+1];
      w_remKeep  = w_qBit ? w_remSub[MW:0] : r_rem;
      w_remNext  = w_remKeep << 1;
      w_quotNext = {r_quot[MAN_W:0], w_qBit};
   end

   logic [LW-1:0]         w_lead;
   logic signed [XW-1:0]  w_leadX, w_expRes;
   logic [NW-1:0]         w_normShift;
   logic [MAN_W-1:0]      w_frac;
   logic                  w_normZero;

   // Normalise: find the leading one, shift it to the top and adjust the exponent
   always_comb begin
      w_lead = '0;
      for (int i = 0; i < NW; i++) begin
         if (r_norm[i]) w_lead = LW'(i);
      end
      w_leadX     = {{(XW-LW){1'b0}}, w_lead};
      w_expRes    = r_exp + w_leadX - REF_X;
      w_normShift = r_norm << (LW'(NW - 1) - w_lead);
      w_frac      = w_normShift[NW-2 -: MAN_W];
      w_normZero  = (r_norm == '0);
   end

   // Control FSM with registered result, flags and out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_result   <= '0;
         r_flags    <= '0;
         r_outValid <= 1'b0;
         r_sign     <= 1'b0;
         r_exp      <= '0;
         r_norm     <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= rs1;
                  r_b     <= rs2;
                  r_op    <= funct3;
                  r_flags <= 4'b0000;
                  r_state <= UNPACK;
               end
            end
            UNPACK: begin
               if (w_special) begin
                  r_result   <= w_specRes;
                  r_flags    <= w_specFlags;
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_rem   <= {1'b0, w_mA};
                  r_quot  <= '0;
                  r_cnt   <= '0;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (r_op == OP_DIV) begin
                  r_rem  <= w_remNext;
                  r_quot <= w_quotNext;
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == DIV_LAST) begin
                     r_norm  <= {1'b0, w_quotNext, {(NW-MAN_W-3){1'b0}}};
                     r_exp   <= w_eAx - w_eBx + BIAS_X;
                     r_sign  <= w_sA ^ w_sB;
                     r_state <= NORM;
                  end
               end else if (r_op == OP_MUL) begin
                  r_norm  <= w_prod;
                  r_exp   <= w_eAx + w_eBx - BIAS_X;
                  r_sign  <= w_sA ^ w_sB;
                  r_state <= NORM;
               end else begin
                  r_norm  <= {w_sum, {(NW-AW-1){1'b0}}};
                  r_exp   <= {{(XW-EXP_W){1'b0}}, w_eBig};
                  r_sign  <= w_sBig;
                  r_state <= NORM;
               end
            end
            NORM: begin
               r_outValid <= 1'b1;
               r_state    <= DONE;
               if (w_normZero) begin
                  r_result <= '0;
               end else if (w_expRes >= EXP_MAX_X) begin
                  r_result <= {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                  r_flags  <= 4'b0010;
               end else if (w_expRes < ONE_X) begin
                  r_result <= {r_sign, {(FW-1){1'b0}}};
                  r_flags  <= 4'b0001;
               end else begin
                  r_result <= {r_sign, w_expRes[EXP_W-1:0], w_frac};
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_outValid;
   assign result    = r_result;
   assign flags     = r_flags;

endmodule
